fetch_stage: RTL

Instruction-fetch stage of the pipelined ARM CPU: owns the program counter, drives the byte address into the combinational instruction ROM, and registers the returned 32-bit word into the IF/ID pipeline register for decode. It handles pipeline stalls, taken-branch redirects from later stages, and halts cleanly when the PC leaves the ROM.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_stage_if.sv | 45 ++++
 rtl/if_id_reg.sv | 36 +++
 rtl/fetch_stage.sv | 103 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the fetch slice: bus widths, fetch FSM states and the IF/ID record.
package cpu_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } if_id_t;

  // Instructions are word sized, so branch targets drop their byte offset.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: ROM port, hazard/branch controls from later stages, IF/ID outputs and status.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               stall;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               if_id_valid;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc;
  logic               halted;
  logic               misalign_err;
  logic [31:0]        fetch_count;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  stall,
    input  redirect,
    input  redirect_pc,
    output if_id_valid,
    output if_id_instr,
    output if_id_pc,
    output halted,
    output misalign_err,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output stall,
    output redirect,
    output redirect_pc,
    input  if_id_valid,
    input  if_id_instr,
    input  if_id_pc,
    input  halted,
    input  misalign_err,
    input  fetch_count
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Squash clears only the valid bit; hold freezes everything.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load_i,
  input  logic   hold_i,
  input  logic   squash_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q, q_d;

  // Squash wins over hold so a wrong-path word never survives a stalled redirect.
  always_comb begin
    q_d = q_q;
    if (squash_i) begin
      q_d.valid = 1'b0;
    end else if (load_i && !hold_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, start/run/halt FSM and fetch counter; IF/ID storage lives in if_id_reg.
// One-cycle ROM-to-IF/ID latency; stall freezes PC and IF/ID, redirect squashes and retargets.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       MEM_BYTES = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input logic           clk,
  input logic           reset_n,
  fetch_stage_if.master fif
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       count_q, count_d;
  logic              pc_ok;
  logic              ifid_load, ifid_hold, ifid_squash;
  if_id_t            ifid_d, ifid_q;

  // One extra bit keeps the range check honest for targets near the top of the address space.
  assign pc_ok = ({1'b0, pc_q} + 65'd3) < 65'(MEM_BYTES);

  assign ifid_d = '{valid: 1'b1, instr: fif.imem_instr, pc: pc_q};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = misalign_q;
    count_d     = count_q;
    ifid_load   = 1'b0;
    ifid_hold   = 1'b0;
    ifid_squash = 1'b0;
    case (state_q)
      S_START: begin
        state_d     = S_RUN;
        ifid_squash = 1'b1;
      end
      S_RUN: begin
        if (fif.redirect) begin
          pc_d        = word_align(fif.redirect_pc);
          misalign_d  = misalign_q | (|fif.redirect_pc[1:0]);
          ifid_squash = 1'b1;
        end else if (fif.stall) begin
          ifid_hold = 1'b1;
        end else if (pc_ok) begin
          ifid_load = 1'b1;
          pc_d      = pc_q + 64'd4;
          count_d   = count_q + 32'd1;
        end else begin
          ifid_squash = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_HALT: begin
        ifid_squash = 1'b1;
        if (fif.redirect) begin
          pc_d       = word_align(fif.redirect_pc);
          misalign_d = misalign_q | (|fif.redirect_pc[1:0]);
          state_d    = S_RUN;
        end
      end
      default: begin
        state_d     = S_START;
        ifid_squash = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_START;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (ifid_load),
    .hold_i   (ifid_hold),
    .squash_i (ifid_squash),
    .d_i      (ifid_d),
    .q_o      (ifid_q)
  );

  assign fif.imem_addr    = pc_q;
  assign fif.if_id_valid  = ifid_q.valid;
  assign fif.if_id_instr  = ifid_q.instr;
  assign fif.if_id_pc     = ifid_q.pc;
  assign fif.halted       = (state_q == S_HALT);
  assign fif.misalign_err = misalign_q;
  assign fif.fetch_count  = count_q;

endmodule
